// File: rtl/pipelined_shifter_if.sv
// Handshake bundle for pipelined_shifter.
//   in_valid/in_ready/in_data/in_amt/in_mode : operation request (source -> shifter)
//   out_valid/out_ready/out_data/out_zero    : shifted result (shifter -> consumer)
// master: the side that issues operations and consumes results; slave: the shifter.
interface pipelined_shifter_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHW   = $clog2(WIDTH)
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_amt;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;

  modport master (
    output in_valid, in_data, in_amt, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_zero
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_zero
  );
endinterface

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter: SLL / SRL / SRA / ROR, one shift-amount bit per stage
// (MSB first), SHW stages deep, full throughput with valid/ready on both sides.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, flushes the whole pipe
//   bus   : pipelined_shifter_if.slave (in_* request side, out_* result side)
// in_ready is combinational from out_ready and the stage valid bits, so a full
// pipe can accept and drain in the same cycle.
module pipelined_shifter #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  pipelined_shifter_if.slave bus
);

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;

  // Single fixed-distance shift; SRA relies on the MSB never changing across stages,
  // so the current MSB is always the original operand MSB.
  function automatic logic [WIDTH-1:0] shift_stage(input logic [WIDTH-1:0] d,
                                                   input logic [1:0]       mode,
                                                   input int unsigned      sh);
    logic [WIDTH-1:0] r;
    case (mode)
      MODE_SLL: r = d << sh;
      MODE_SRL: r = d >> sh;
      MODE_SRA: r = WIDTH'($signed(d) >>> sh);
      default:  r = (d >> sh) | (d << (WIDTH - sh));
    endcase
    return r;
  endfunction

  // Stage state
  logic [SHW-1:0]   v_q;
  logic [WIDTH-1:0] data_q [SHW];
  logic [SHW-1:0]   amt_q  [SHW];
  logic [1:0]       mode_q [SHW];
  logic             zero_q;

  // Stage inputs and next values
  logic [SHW-1:0]   en;
  logic             stage_full;
  logic [WIDTH-1:0] src_data [SHW];
  logic [SHW-1:0]   src_amt  [SHW];
  logic [1:0]       src_mode [SHW];
  logic [SHW-1:0]   src_v;
  logic [WIDTH-1:0] nxt_data [SHW];
  logic             nxt_zero;

  // Advance enables: stage k may load unless it and every stage after it is
  // occupied while the consumer stalls. Written flat to avoid a chained vector.
  always_comb begin
    en         = '0;
    stage_full = 1'b0;
    for (int k = 0; k < int'(SHW); k++) begin
      stage_full = 1'b1;
      for (int j = k; j < int'(SHW); j++) begin
        stage_full = stage_full & v_q[j];
      end
      en[k] = bus.out_ready | ~stage_full;
    end
  end

  // Stage sources and the shift each stage applies (2^(SHW-1-k) when its bit is set)
  always_comb begin
    src_data[0] = bus.in_data;
    src_amt[0]  = bus.in_amt;
    src_mode[0] = bus.in_mode;
    src_v       = '0;
    src_v[0]    = bus.in_valid;
    for (int k = 1; k < int'(SHW); k++) begin
      src_data[k] = data_q[k-1];
      src_amt[k]  = amt_q[k-1];
      src_mode[k] = mode_q[k-1];
      src_v[k]    = v_q[k-1];
    end
    for (int k = 0; k < int'(SHW); k++) begin
      if (src_amt[k][int'(SHW) - 1 - k]) begin
        nxt_data[k] = shift_stage(src_data[k], src_mode[k], 32'(1) << (int'(SHW) - 1 - k));
      end else begin
        nxt_data[k] = src_data[k];
      end
    end
    nxt_zero = src_v[SHW-1] & (nxt_data[SHW-1] == '0);
  end

  // Stage registers: load when enabled, otherwise hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q    <= '0;
      zero_q <= 1'b0;
      for (int k = 0; k < int'(SHW); k++) begin
        data_q[k] <= '0;
        amt_q[k]  <= '0;
        mode_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < int'(SHW); k++) begin
        if (en[k]) begin
          v_q[k]    <= src_v[k];
          data_q[k] <= nxt_data[k];
          amt_q[k]  <= src_amt[k];
          mode_q[k] <= src_mode[k];
        end
      end
      if (en[SHW-1]) begin
        zero_q <= nxt_zero;
      end
    end
  end

  assign bus.in_ready  = en[0];
  assign bus.out_valid = v_q[SHW-1];
  assign bus.out_data  = data_q[SHW-1];
  assign bus.out_zero  = zero_q;

endmodule

// File: tb/tb_pipelined_shifter.sv
// Scoreboard bench for pipelined_shifter (WIDTH=16, four stages).
module tb_pipelined_shifter;
  localparam int unsigned W = 16;
  localparam int unsigned S = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipelined_shifter_if #(.WIDTH(W), .SHW(S)) bus ();

  pipelined_shifter #(.WIDTH(W), .SHW(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  // Bit-level reference: each output bit picked from the operand directly.
  function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic [S-1:0] amt,
                                         input logic [1:0] mode);
    logic [W-1:0] r;
    int a;
    a = int'(amt);
    for (int i = 0; i < int'(W); i++) begin
      case (mode)
        2'b00:   r[i] = (i >= a) ? d[i-a] : 1'b0;
        2'b01:   r[i] = (i + a < int'(W)) ? d[i+a] : 1'b0;
        2'b10:   r[i] = (i + a < int'(W)) ? d[i+a] : d[W-1];
        default: r[i] = d[(i + a) % int'(W)];
      endcase
    end
    return r;
  endfunction

  // Drive one cycle of stimulus, sample outputs before the edge, record accepts.
  task automatic cycle(input logic iv, input logic [W-1:0] d, input logic [S-1:0] a,
                       input logic [1:0] m, input logic ordy,
                       output logic acc, output logic rdy, output logic ov,
                       output logic fire, output logic [W-1:0] got, output logic z);
    @(negedge clk);
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.in_amt    = a;
    bus.in_mode   = m;
    bus.out_ready = ordy;
    #1;
    rdy  = bus.in_ready;
    acc  = iv & bus.in_ready;
    ov   = bus.out_valid;
    fire = bus.out_valid & ordy;
    got  = bus.out_data;
    z    = bus.out_zero;
    if (acc) exp_q.push_back(model(d, a, m));
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_amt = '0; bus.in_mode = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b required=0", bus.out_valid); end
    checks++; if (bus.out_data !== '0) begin errors++; $display("FAIL reset_out_data got=%h required=0000", bus.out_data); end
    checks++; if (bus.out_zero !== 1'b0) begin errors++; $display("FAIL reset_out_zero got=%b required=0", bus.out_zero); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b required=1", bus.in_ready); end
  endtask

  task automatic test_latency();
    logic acc, rdy, ov, fire, z; logic [W-1:0] got, e; int first;
    first = -1;
    cycle(1'b1, 16'h00FF, 4'd8, 2'b00, 1'b1, acc, rdy, ov, fire, got, z);
    checks++; if (acc !== 1'b1) begin errors++; $display("FAIL latency_accept got=%b required=1", acc); end
    for (int k = 1; k <= 8; k++) begin
      cycle(1'b0, '0, '0, 2'b00, 1'b1, acc, rdy, ov, fire, got, z);
      if (fire) begin
        if (first < 0) first = k;
        checks++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
        if (got !== 16'hFF00 || got !== e || z !== 1'b0) begin
          errors++; $display("FAIL latency_data got=%h/%b required=ff00/0", got, z);
        end
      end
    end
    checks++; if (first != 4) begin errors++; $display("FAIL latency_cycles got=%0d required=4", first); end
  endtask

  task automatic test_vectors();
    logic [W-1:0] vd [5] = '{16'h8000, 16'h8000, 16'h1234, 16'h8001, 16'h8000};
    logic [S-1:0] va [5] = '{4'd4, 4'd15, 4'd4, 4'd1, 4'd1};
    logic [1:0]   vm [5] = '{2'b10, 2'b01, 2'b11, 2'b00, 2'b00};
    logic [W-1:0] vr [5] = '{16'hF800, 16'h0001, 16'h4123, 16'h0002, 16'h0000};
    logic acc, rdy, ov, fire, z; logic [W-1:0] got, e; int n;
    n = 0;
    for (int i = 0; i < 16; i++) begin
      if (i < 5) cycle(1'b1, vd[i], va[i], vm[i], 1'b1, acc, rdy, ov, fire, got, z);
      else       cycle(1'b0, '0, '0, 2'b00, 1'b1, acc, rdy, ov, fire, got, z);
      if (fire) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
        checks++;
        if (n >= 5 || got !== vr[n] || got !== e || z !== (vr[n] == '0)) begin
          errors++; $display("FAIL vector_%0d got=%h/%b required=%h", n, got, z, (n < 5) ? vr[n] : 16'hxxxx);
        end
        n++;
      end
    end
    checks++; if (n != 5) begin errors++; $display("FAIL vector_count got=%0d required=5", n); end
  endtask

  task automatic test_back_to_back();
    logic acc, rdy, ov, fire, z; logic [W-1:0] got, e; int nacc, nout, ffirst, flast;
    nacc = 0; nout = 0; ffirst = -1; flast = -1;
    for (int i = 0; i < 26; i++) begin
      if (i < 16) cycle(1'b1, W'($urandom), S'($urandom), 2'($urandom), 1'b1, acc, rdy, ov, fire, got, z);
      else        cycle(1'b0, '0, '0, 2'b00, 1'b1, acc, rdy, ov, fire, got, z);
      if (acc) nacc++;
      if (fire) begin
        if (ffirst < 0) ffirst = i;
        flast = i; nout++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
        checks++;
        if (got !== e || z !== (e == '0)) begin errors++; $display("FAIL b2b_data got=%h/%b required=%h", got, z, e); end
      end
    end
    checks++; if (nacc != 16) begin errors++; $display("FAIL b2b_accepts got=%0d required=16", nacc); end
    checks++; if (nout != 16 || flast - ffirst != 15) begin
      errors++; $display("FAIL b2b_consecutive got=%0d results over %0d cycles required=16 over 16", nout, flast - ffirst + 1);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] od [6]; logic [S-1:0] oa [6]; logic [1:0] om [6];
    logic acc, rdy, ov, fire, z; logic [W-1:0] got, e, held; logic have_held; int idx, nout;
    for (int i = 0; i < 6; i++) begin od[i] = W'($urandom); oa[i] = S'($urandom); om[i] = 2'($urandom); end
    idx = 0; have_held = 1'b0; held = '0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, od[idx], oa[idx], om[idx], 1'b0, acc, rdy, ov, fire, got, z);
      if (acc) idx++;
      if (idx == 4 && !acc) begin
        checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL bp_in_ready got=%b required=0", rdy); end
      end
      if (ov) begin
        if (!have_held) begin held = got; have_held = 1'b1; end
        else begin
          checks++; if (got !== held) begin errors++; $display("FAIL bp_hold got=%h required=%h", got, held); end
        end
      end
    end
    checks++; if (idx != 4) begin errors++; $display("FAIL bp_capacity got=%0d required=4", idx); end
    nout = 0;
    for (int i = 0; i < 30 && nout < 6; i++) begin
      if (idx < 6) cycle(1'b1, od[idx], oa[idx], om[idx], 1'b1, acc, rdy, ov, fire, got, z);
      else         cycle(1'b0, '0, '0, 2'b00, 1'b1, acc, rdy, ov, fire, got, z);
      if (acc) idx++;
      if (fire) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
        checks++;
        if (got !== e || got !== model(od[nout], oa[nout], om[nout])) begin
          errors++; $display("FAIL bp_data_%0d got=%h required=%h", nout, got, model(od[nout], oa[nout], om[nout]));
        end
        nout++;
      end
    end
    checks++; if (nout != 6 || exp_q.size() != 0) begin
      errors++; $display("FAIL bp_drain got=%0d results, %0d left required=6, 0", nout, exp_q.size());
    end
  endtask

  task automatic test_bubble();
    logic pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic acc, rdy, ov, fire, z; logic [W-1:0] got, e; int nout; logic e_done;
    for (int i = 0; i < 6; i++) begin
      cycle(pat[i], W'(i + 16'h0101), S'(i), 2'b11, 1'b0, acc, rdy, ov, fire, got, z);
      checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL bubble_ready_%0d got=%b required=1", i, rdy); end
    end
    cycle(1'b1, 16'hBEEF, 4'd3, 2'b10, 1'b0, acc, rdy, ov, fire, got, z);
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL bubble_full got=%b required=0", rdy); end
    nout = 0; e_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle(!e_done, 16'hBEEF, 4'd3, 2'b10, 1'b1, acc, rdy, ov, fire, got, z);
      if (acc) e_done = 1'b1;
      if (fire) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
        checks++; if (got !== e) begin errors++; $display("FAIL bubble_data got=%h required=%h", got, e); end
        nout++;
      end
    end
    checks++; if (nout != 5) begin errors++; $display("FAIL bubble_count got=%0d required=5", nout); end
  endtask

  task automatic test_reset_flush();
    logic acc, rdy, ov, fire, z; logic [W-1:0] got, e; int nout;
    for (int i = 0; i < 3; i++) cycle(1'b1, W'($urandom), S'($urandom), 2'($urandom), 1'b0, acc, rdy, ov, fire, got, z);
    cycle(1'b0, '0, '0, 2'b00, 1'b0, acc, rdy, ov, fire, got, z);
    cycle(1'b0, '0, '0, 2'b00, 1'b0, acc, rdy, ov, fire, got, z);
    checks++; if (ov !== 1'b1) begin errors++; $display("FAIL flush_pre_valid got=%b required=1", ov); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_async got=%b required=0", bus.out_valid); end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    nout = 0;
    cycle(1'b1, 16'h0F0F, 4'd5, 2'b11, 1'b1, acc, rdy, ov, fire, got, z);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, '0, '0, 2'b00, 1'b1, acc, rdy, ov, fire, got, z);
      if (fire) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
        checks++; if (got !== 16'h7878 || got !== e) begin errors++; $display("FAIL flush_first got=%h required=7878", got); end
        nout++;
      end
    end
    checks++; if (nout != 1) begin errors++; $display("FAIL flush_count got=%0d required=1", nout); end
  endtask

  task automatic test_random();
    logic acc, rdy, ov, fire, z; logic [W-1:0] got, e, d; logic [S-1:0] a; logic [1:0] m;
    int nacc, nout, bad;
    nacc = 0; nout = 0; bad = 0;
    d = W'($urandom); a = S'($urandom); m = 2'($urandom);
    for (int i = 0; i < 40000 && nout < 10000; i++) begin
      cycle((nacc < 10000) && ($urandom_range(3) != 0), d, a, m, $urandom_range(3) != 0,
            acc, rdy, ov, fire, got, z);
      if (acc) begin nacc++; d = W'($urandom); a = S'($urandom); m = 2'($urandom); end
      if (fire) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
        checks++;
        if (got !== e || z !== (e == '0)) begin
          errors++;
          if (bad < 10) $display("FAIL random_%0d got=%h/%b required=%h", nout, got, z, e);
          bad++;
        end
        nout++;
      end
    end
    checks++; if (nout != 10000 || exp_q.size() != 0) begin
      errors++; $display("FAIL random_count got=%0d results, %0d left required=10000, 0", nout, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_vectors();
    test_back_to_back();
    test_backpressure();
    test_bubble();
    test_reset_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
